e_branch_resolve: RTL and testbench

- Execute-stage consumer of the decode-stage branch/jump control codes (bop, jump).
- Latches the decoded code, operands and PC context into a D/E stage register.
- Evaluates the branch condition and computes the target.
- Issues a registered one-cycle PC redirect plus flush to fetch/decode, and squashes the wrong-path instruction behind it.

---
 rtl/e_branch_resolve_pkg.sv | 41 ++++
 rtl/e_branch_resolve_if.sv | 55 +++++
 rtl/e_branch_resolve_cond_eval.sv | 86 ++++++++
 rtl/e_branch_resolve.sv | 182 ++++++++++++++++++
 tb/tb_e_branch_resolve.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/e_branch_resolve_pkg.sv
// -----------------------------------------------------------------------------
// br_pkg : shared types and helpers for the execute-stage branch resolver.
//   bop_e   : decoded branch op (BOP_NONE..BOP_BGEZ, BOP_RSVD)
//   jump_e  : decoded jump type (JMP_NONE, JMP_J, JMP_JR, JMP_RSVD)
//   fsm_e   : redirect sequencer state (RUN, FLUSH)
//   SHAMT_BR: word-offset shift applied to the branch immediate
//   sat_inc32: saturating 32-bit increment used by the optional statistics
// -----------------------------------------------------------------------------
package br_pkg;

  typedef enum logic [2:0] {
    BOP_NONE = 3'b000,
    BOP_BEQ  = 3'b001,
    BOP_BNE  = 3'b010,
    BOP_BLEZ = 3'b011,
    BOP_BGTZ = 3'b100,
    BOP_BLTZ = 3'b101,
    BOP_BGEZ = 3'b110,
    BOP_RSVD = 3'b111
  } bop_e;

  typedef enum logic [1:0] {
    JMP_NONE = 2'b00,
    JMP_J    = 2'b01,
    JMP_JR   = 2'b10,
    JMP_RSVD = 2'b11
  } jump_e;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fsm_e;

  localparam int SHAMT_BR = 2;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/e_branch_resolve_if.sv
// -----------------------------------------------------------------------------
// e_branch_resolve_if : decode -> execute branch control bundle.
//   master : decode side, drives i_br_* and observes o_br_*
//   slave  : execute-stage resolver (e_branch_resolve)
// Optional macro BRANCH_STATS_EN adds o_br_n_branch / o_br_n_taken /
// o_br_n_mispredict statistics outputs.
// -----------------------------------------------------------------------------
interface e_branch_resolve_if #(
  parameter int XLEN = 32
);
  logic             i_br_valid;
  logic             i_br_stall;
  logic [2:0]       i_br_bop;
  logic [1:0]       i_br_jump;
  logic [XLEN-1:0]  i_br_pc4;
  logic [XLEN-1:0]  i_br_imm;
  logic [25:0]      i_br_jidx;
  logic [XLEN-1:0]  i_br_rs;
  logic [XLEN-1:0]  i_br_rt;
  logic             o_br_redirect;
  logic [XLEN-1:0]  o_br_target;
  logic             o_br_flush;
  logic             o_br_illegal;
`ifdef BRANCH_STATS_EN
  logic [31:0]      o_br_n_branch;
  logic [31:0]      o_br_n_taken;
  logic [31:0]      o_br_n_mispredict;

  modport master (
    output i_br_valid, i_br_stall, i_br_bop, i_br_jump, i_br_pc4, i_br_imm,
           i_br_jidx, i_br_rs, i_br_rt,
    input  o_br_redirect, o_br_target, o_br_flush, o_br_illegal,
           o_br_n_branch, o_br_n_taken, o_br_n_mispredict
  );

  modport slave (
    input  i_br_valid, i_br_stall, i_br_bop, i_br_jump, i_br_pc4, i_br_imm,
           i_br_jidx, i_br_rs, i_br_rt,
    output o_br_redirect, o_br_target, o_br_flush, o_br_illegal,
           o_br_n_branch, o_br_n_taken, o_br_n_mispredict
  );
`else
  modport master (
    output i_br_valid, i_br_stall, i_br_bop, i_br_jump, i_br_pc4, i_br_imm,
           i_br_jidx, i_br_rs, i_br_rt,
    input  o_br_redirect, o_br_target, o_br_flush, o_br_illegal
  );

  modport slave (
    input  i_br_valid, i_br_stall, i_br_bop, i_br_jump, i_br_pc4, i_br_imm,
           i_br_jidx, i_br_rs, i_br_rt,
    output o_br_redirect, o_br_target, o_br_flush, o_br_illegal
  );
`endif
endinterface

// File: rtl/e_branch_resolve_cond_eval.sv
// -----------------------------------------------------------------------------
// br_cond_eval : combinational branch condition and target evaluation.
//   bop, jump        : decoded control codes (see br_pkg)
//   rs, rt           : forwarded operands, compared as signed XLEN values
//   pc4, imm, jidx   : PC+4, sign-extended offset, jump index
//   taken            : instruction redirects the PC
//   target           : redirect address (meaningful when taken)
//   illegal          : reserved code; never reported as taken
// A jump code overrides any branch op.
// -----------------------------------------------------------------------------
module br_cond_eval
  import br_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      bop,
  input  logic [1:0]      jump,
  input  logic [XLEN-1:0] rs,
  input  logic [XLEN-1:0] rt,
  input  logic [XLEN-1:0] pc4,
  input  logic [XLEN-1:0] imm,
  input  logic [25:0]     jidx,
  output logic            taken,
  output logic [XLEN-1:0] target,
  output logic            illegal
);

  logic signed [XLEN-1:0] rs_signed_s;
  logic                   cond_s;
  logic                   bop_rsvd_s;
  logic [XLEN-1:0]        br_tgt_s;
  logic [XLEN-1:0]        j_tgt_s;

  assign rs_signed_s = rs;
  // Wraps naturally modulo 2^XLEN.
  assign br_tgt_s    = pc4 + (imm << SHAMT_BR);
  // Region bits come from PC+4, the rest from the word-aligned index.
  assign j_tgt_s     = {pc4[XLEN-1:28], jidx, 2'b00};

  // Branch condition from the decoded op.
  always_comb begin
    cond_s     = 1'b0;
    bop_rsvd_s = 1'b0;
    case (bop_e'(bop))
      BOP_NONE: cond_s = 1'b0;
      BOP_BEQ:  cond_s = (rs == rt);
      BOP_BNE:  cond_s = (rs != rt);
      BOP_BLEZ: cond_s = (rs_signed_s <= $signed({XLEN{1'b0}}));
      BOP_BGTZ: cond_s = (rs_signed_s >  $signed({XLEN{1'b0}}));
      BOP_BLTZ: cond_s = rs_signed_s[XLEN-1];
      BOP_BGEZ: cond_s = ~rs_signed_s[XLEN-1];
      BOP_RSVD: bop_rsvd_s = 1'b1;
      default:  cond_s = 1'b0;
    endcase
  end

  // Jump type selects between branch result, direct jump and register jump.
  always_comb begin
    taken   = 1'b0;
    target  = br_tgt_s;
    illegal = 1'b0;
    case (jump_e'(jump))
      JMP_NONE: begin
        taken   = cond_s;
        target  = br_tgt_s;
        illegal = bop_rsvd_s;
      end
      JMP_J: begin
        taken  = 1'b1;
        target = j_tgt_s;
      end
      JMP_JR: begin
        taken  = 1'b1;
        target = rs;
      end
      JMP_RSVD: begin
        illegal = 1'b1;
      end
      default: begin
        taken   = 1'b0;
        illegal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/e_branch_resolve.sv
// -----------------------------------------------------------------------------
// e_branch_resolve : execute-stage branch/jump resolver.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   br       : e_branch_resolve_if.slave
//     i_br_valid/stall        decode valid, hazard hold of the D/E register
//     i_br_bop/jump           decoded branch op / jump type
//     i_br_pc4/imm/jidx/rs/rt instruction context and forwarded operands
//     o_br_redirect/target    registered one-cycle PC redirect and address
//     o_br_flush              kill fetch/decode, FLUSH_CYCLES long
//     o_br_illegal            registered one-cycle reserved-code pulse
// Parameters: XLEN (datapath/PC width), FLUSH_CYCLES (1..3).
// Optional macro BRANCH_STATS_EN: saturating counters o_br_n_branch,
// o_br_n_taken and o_br_n_mispredict.
// -----------------------------------------------------------------------------
module e_branch_resolve
  import br_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  e_branch_resolve_if.slave  br
);

  // D/E stage register
  logic            valid_r;
  logic            resolved_r;
  logic [2:0]      bop_r;
  logic [1:0]      jump_r;
  logic [XLEN-1:0] pc4_r;
  logic [XLEN-1:0] imm_r;
  logic [25:0]     jidx_r;
  logic [XLEN-1:0] rs_r;
  logic [XLEN-1:0] rt_r;

  // Redirect sequencer
  fsm_e            state_r;
  logic [1:0]      flush_cnt_r;
  logic            redirect_r;
  logic [XLEN-1:0] target_r;
  logic            flush_r;
  logic            illegal_r;

  logic            taken_s;
  logic            illegal_s;
  logic [XLEN-1:0] target_s;
  logic            resolve_s;
  logic            squash_s;

  br_cond_eval #(.XLEN(XLEN)) u_cond_eval (
    .bop     (bop_r),
    .jump    (jump_r),
    .rs      (rs_r),
    .rt      (rt_r),
    .pc4     (pc4_r),
    .imm     (imm_r),
    .jidx    (jidx_r),
    .taken   (taken_s),
    .target  (target_s),
    .illegal (illegal_s)
  );

  // An instruction resolves once, and never while a flush is in progress.
  assign resolve_s = valid_r & ~resolved_r & (state_r == RUN);
  // The capture behind a taken instruction and all captures during FLUSH
  // are wrong-path.
  assign squash_s  = (state_r == FLUSH) | (resolve_s & taken_s);

  // D/E stage register: capture when not stalled, else hold and mark resolved.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r    <= 1'b0;
      resolved_r <= 1'b0;
      bop_r      <= 3'b000;
      jump_r     <= 2'b00;
      pc4_r      <= {XLEN{1'b0}};
      imm_r      <= {XLEN{1'b0}};
      jidx_r     <= 26'd0;
      rs_r       <= {XLEN{1'b0}};
      rt_r       <= {XLEN{1'b0}};
    end else if (!br.i_br_stall) begin
      valid_r    <= br.i_br_valid & ~squash_s;
      resolved_r <= 1'b0;
      bop_r      <= br.i_br_bop;
      jump_r     <= br.i_br_jump;
      pc4_r      <= br.i_br_pc4;
      imm_r      <= br.i_br_imm;
      jidx_r     <= br.i_br_jidx;
      rs_r       <= br.i_br_rs;
      rt_r       <= br.i_br_rt;
    end else if (resolve_s) begin
      resolved_r <= 1'b1;
    end else begin
      resolved_r <= resolved_r;
    end
  end

  // Redirect sequencer with registered redirect/target/flush/illegal outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= RUN;
      flush_cnt_r <= 2'd0;
      redirect_r  <= 1'b0;
      target_r    <= {XLEN{1'b0}};
      flush_r     <= 1'b0;
      illegal_r   <= 1'b0;
    end else begin
      illegal_r <= resolve_s & illegal_s;
      case (state_r)
        RUN: begin
          if (resolve_s && taken_s) begin
            state_r     <= FLUSH;
            flush_cnt_r <= 2'(FLUSH_CYCLES - 1);
            redirect_r  <= 1'b1;
            target_r    <= target_s;
            flush_r     <= 1'b1;
          end else begin
            redirect_r  <= 1'b0;
            flush_r     <= 1'b0;
          end
        end
        FLUSH: begin
          redirect_r <= 1'b0;
          if (flush_cnt_r == 2'd0) begin
            state_r <= RUN;
            flush_r <= 1'b0;
          end else begin
            flush_cnt_r <= flush_cnt_r - 2'd1;
          end
        end
        default: begin
          state_r    <= RUN;
          redirect_r <= 1'b0;
          flush_r    <= 1'b0;
        end
      endcase
    end
  end

  assign br.o_br_redirect = redirect_r;
  assign br.o_br_target   = target_r;
  assign br.o_br_flush    = flush_r;
  assign br.o_br_illegal  = illegal_r;

`ifdef BRANCH_STATS_EN
  logic [31:0] n_branch_r;
  logic [31:0] n_taken_r;
  logic [31:0] n_mispredict_r;
  logic        is_branch_s;

  // Conditional branches only: no jump code and a real (non-reserved) op.
  assign is_branch_s = (jump_r == 2'b00) && (bop_r != 3'b000) && (bop_r != 3'b111);

  // Saturating statistics, counted at resolution time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_branch_r     <= 32'd0;
      n_taken_r      <= 32'd0;
      n_mispredict_r <= 32'd0;
    end else begin
      if (resolve_s && is_branch_s) begin
        n_branch_r <= sat_inc32(n_branch_r);
      end else begin
        n_branch_r <= n_branch_r;
      end
      if (resolve_s && taken_s) begin
        n_taken_r      <= sat_inc32(n_taken_r);
        n_mispredict_r <= sat_inc32(n_mispredict_r);
      end else begin
        n_taken_r      <= n_taken_r;
        n_mispredict_r <= n_mispredict_r;
      end
    end
  end

  assign br.o_br_n_branch     = n_branch_r;
  assign br.o_br_n_taken      = n_taken_r;
  assign br.o_br_n_mispredict = n_mispredict_r;
`endif

endmodule

// File: tb/tb_e_branch_resolve.sv
// -----------------------------------------------------------------------------
// tb_e_branch_resolve : directed plus randomized bench for e_branch_resolve.
// A transaction-level reference model predicts outputs each cycle; a negedge
// process compares them. Directed sections pin the model with literal values.
// -----------------------------------------------------------------------------
module tb_e_branch_resolve;

  localparam int FC = 1;

  typedef struct packed {
    bit        v;
    bit        done;
    bit [2:0]  bop;
    bit [1:0]  jmp;
    bit [31:0] pc4;
    bit [31:0] imm;
    bit [25:0] jidx;
    bit [31:0] rs;
    bit [31:0] rt;
  } ins_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b1;

  e_branch_resolve_if #(.XLEN(32)) bif ();

  e_branch_resolve #(.XLEN(32), .FLUSH_CYCLES(FC)) dut (
    .clk (clk),
    .rst (rst),
    .br  (bif)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  ins_t      m_e;
  int        m_fl;
  bit        exp_redirect, exp_flush, exp_illegal;
  bit [31:0] exp_target;
  int        m_nb, m_nt;
  bit        m_can, m_tk, m_il, m_sq;
  bit [31:0] m_tg;
  ins_t      m_in;

  function automatic void ref_eval(input ins_t x, output bit tk, output bit [31:0] tg,
                                   output bit il);
    int signed a;
    int signed b;
    a = x.rs; b = x.rt; tk = 0; il = 0;
    tg = x.pc4 + x.imm * 4;
    if (x.jmp == 2'd3) il = 1;
    else if (x.jmp == 2'd1) begin tk = 1; tg = (x.pc4 & 32'hF000_0000) | (x.jidx * 4); end
    else if (x.jmp == 2'd2) begin tk = 1; tg = x.rs; end
    else begin
      case (x.bop)
        3'd1: tk = (a == b);
        3'd2: tk = (a != b);
        3'd3: tk = (a <= 0);
        3'd4: tk = (a > 0);
        3'd5: tk = (a < 0);
        3'd6: tk = (a >= 0);
        3'd7: il = 1;
        default: tk = 0;
      endcase
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_e = '0; m_fl = 0; exp_redirect = 0; exp_flush = 0; exp_illegal = 0;
      exp_target = 0; m_nb = 0; m_nt = 0;
    end else begin
      m_can = m_e.v && !m_e.done && (m_fl == 0);
      ref_eval(m_e, m_tk, m_tg, m_il);
      m_tk = m_tk && m_can;
      m_il = m_il && m_can;
      if (m_can && m_e.jmp == 0 && m_e.bop != 0 && m_e.bop != 7) m_nb++;
      if (m_tk) m_nt++;
      m_sq = m_tk || (m_fl > 0);
      exp_redirect = m_tk;
      exp_illegal  = m_il;
      if (m_tk) exp_target = m_tg;
      if (m_fl > 0) m_fl--;
      if (m_tk) m_fl = FC;
      exp_flush = (m_fl > 0);
      if (!bif.i_br_stall) begin
        m_in.v = bif.i_br_valid && !m_sq; m_in.done = 0;
        m_in.bop = bif.i_br_bop; m_in.jmp = bif.i_br_jump; m_in.pc4 = bif.i_br_pc4;
        m_in.imm = bif.i_br_imm; m_in.jidx = bif.i_br_jidx; m_in.rs = bif.i_br_rs;
        m_in.rt = bif.i_br_rt;
        m_e = m_in;
      end else if (m_can) begin
        m_e.done = 1;
      end
    end
  end

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_redirect", bif.o_br_redirect, exp_redirect);
      check("m_target",   bif.o_br_target,   exp_target);
      check("m_flush",    bif.o_br_flush,    exp_flush);
      check("m_illegal",  bif.o_br_illegal,  exp_illegal);
`ifdef BRANCH_STATS_EN
      check("m_n_branch",     bif.o_br_n_branch,     m_nb);
      check("m_n_taken",      bif.o_br_n_taken,      m_nt);
      check("m_n_mispredict", bif.o_br_n_mispredict, m_nt);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit [2:0] bop, input bit [1:0] j, input bit [31:0] pc4,
                       input bit [31:0] imm, input bit [25:0] jidx,
                       input bit [31:0] rs, input bit [31:0] rt);
    bif.i_br_valid = 1'b1; bif.i_br_bop = bop; bif.i_br_jump = j; bif.i_br_pc4 = pc4;
    bif.i_br_imm = imm; bif.i_br_jidx = jidx; bif.i_br_rs = rs; bif.i_br_rt = rt;
  endtask

  // Issue one instruction; return once its registered result is visible.
  task automatic one(input bit [2:0] bop, input bit [1:0] j, input bit [31:0] pc4,
                     input bit [31:0] imm, input bit [25:0] jidx,
                     input bit [31:0] rs, input bit [31:0] rt);
    drive(bop, j, pc4, imm, jidx, rs, rt);
    cyc();
    bif.i_br_valid = 1'b0;
    cyc();
  endtask

  task automatic drain();
    bif.i_br_valid = 1'b0;
    bif.i_br_stall = 1'b0;
    repeat (3) cyc();
  endtask

  bit [3:0] tk_neg = 4'b0101;  // blez,bgtz,bltz,bgez with rs=0x80000000
  bit [3:0] tk_zero = 4'b1001; // same ops with rs=0
  int       cnt;
  bit [31:0] r;

  initial begin
    bif.i_br_valid = 0; bif.i_br_stall = 0; bif.i_br_bop = 0; bif.i_br_jump = 0;
    bif.i_br_pc4 = 0; bif.i_br_imm = 0; bif.i_br_jidx = 0; bif.i_br_rs = 0; bif.i_br_rt = 0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_redirect", bif.o_br_redirect, 32'd0);
    check("rst_target",   bif.o_br_target,   32'd0);
    check("rst_flush",    bif.o_br_flush,    32'd0);
    check("rst_illegal",  bif.o_br_illegal,  32'd0);
    rst = 1'b0;
    cyc();

    // beq taken
    one(3'd1, 2'd0, 32'h0040_0010, 32'h3, 26'd0, 32'h5, 32'h5);
    check("beq_redirect", bif.o_br_redirect, 32'd1);
    check("beq_target",   bif.o_br_target,   32'h0040_001C);
    check("beq_flush",    bif.o_br_flush,    32'd1);
    cyc();
    check("beq_redirect_end", bif.o_br_redirect, 32'd0);
    check("beq_flush_end",    bif.o_br_flush,    32'd0);
    drain();

    // bne not taken
    one(3'd2, 2'd0, 32'h0000_1000, 32'h8, 26'd0, 32'h7, 32'h7);
    check("bne_redirect", bif.o_br_redirect, 32'd0);
    check("bne_flush",    bif.o_br_flush,    32'd0);
    drain();

    // single-operand compares
    for (int i = 0; i < 4; i++) begin
      one(3'(3 + i), 2'd0, 32'h100, 32'h1, 26'd0, 32'h8000_0000, 32'h0);
      check("cmp_neg", bif.o_br_redirect, 32'(tk_neg[i]));
      drain();
      one(3'(3 + i), 2'd0, 32'h100, 32'h1, 26'd0, 32'h0, 32'h0);
      check("cmp_zero", bif.o_br_redirect, 32'(tk_zero[i]));
      drain();
    end

    // jumps
    one(3'd0, 2'd1, 32'hA000_0004, 32'h0, 26'h100, 32'h0, 32'h0);
    check("j_target", bif.o_br_target, 32'hA000_0400);
    drain();
    one(3'd0, 2'd2, 32'h0, 32'h0, 26'h0, 32'h1234_5678, 32'h0);
    check("jr_target", bif.o_br_target, 32'h1234_5678);
    drain();
    one(3'd1, 2'd1, 32'hA000_0004, 32'h5, 26'h100, 32'h0, 32'h0);
    check("jump_wins", bif.o_br_target, 32'hA000_0400);
    drain();

    // wrong-path instruction behind a taken beq is squashed
    drive(3'd1, 2'd0, 32'h0040_0010, 32'h3, 26'd0, 32'h5, 32'h5);
    cyc();
    drive(3'd0, 2'd1, 32'hA000_0004, 32'h0, 26'h100, 32'h0, 32'h0);
    cyc();
    bif.i_br_valid = 1'b0;
    cnt = int'(bif.o_br_redirect);
    repeat (4) begin cyc(); cnt += int'(bif.o_br_redirect); end
    check("squash_cnt",    cnt, 32'd1);
    check("squash_target", bif.o_br_target, 32'h0040_001C);
    drain();

    // taken beq held by stall for 3 cycles
    drive(3'd1, 2'd0, 32'h0000_2000, 32'hFFFF_FFFF, 26'd0, 32'h9, 32'h9);
    cyc();
    bif.i_br_valid = 1'b0; bif.i_br_stall = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (i == 2) bif.i_br_stall = 1'b0;
      cnt += int'(bif.o_br_redirect);
    end
    check("stall_cnt",    cnt, 32'd1);
    check("stall_target", bif.o_br_target, 32'h0000_1FFC);
    drain();

    // reserved bop
    one(3'd7, 2'd0, 32'h0, 32'h0, 26'd0, 32'h0, 32'h0);
    check("rsvd_illegal",  bif.o_br_illegal,  32'd1);
    check("rsvd_redirect", bif.o_br_redirect, 32'd0);
    cyc();
    check("rsvd_illegal_end", bif.o_br_illegal, 32'd0);
    drain();

`ifdef BRANCH_STATS_EN
    begin
      int nb0, nt0;
      nb0 = bif.o_br_n_branch; nt0 = bif.o_br_n_taken;
      one(3'd1, 2'd0, 32'h0, 32'h1, 26'd0, 32'h1, 32'h1); drain();
      one(3'd2, 2'd0, 32'h0, 32'h1, 26'd0, 32'h1, 32'h2); drain();
      one(3'd1, 2'd0, 32'h0, 32'h1, 26'd0, 32'h1, 32'h2); drain();
      check("stats_branch", bif.o_br_n_branch - nb0, 32'd3);
      check("stats_taken",  bif.o_br_n_taken - nt0,  32'd2);
    end
`endif

    // reset in the middle of FLUSH
    one(3'd1, 2'd0, 32'h0040_0010, 32'h3, 26'd0, 32'h5, 32'h5);
    check("pre_rst_flush", bif.o_br_flush, 32'd1);
    rst = 1'b1;
    #1;
    check("arst_redirect", bif.o_br_redirect, 32'd0);
    check("arst_target",   bif.o_br_target,   32'd0);
    check("arst_flush",    bif.o_br_flush,    32'd0);
    check("arst_illegal",  bif.o_br_illegal,  32'd0);
    cyc();
    rst = 1'b0;
    cyc();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bif.i_br_valid = ($urandom_range(0, 3) != 0);
      bif.i_br_stall = ($urandom_range(0, 5) == 0);
      bif.i_br_bop   = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      bif.i_br_jump  = (r < 6) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
      case ($urandom_range(0, 3))
        0: bif.i_br_rs = 32'h0;
        1: bif.i_br_rs = 32'h8000_0000;
        2: bif.i_br_rs = 32'($signed($urandom_range(0, 6)) - 3);
        default: bif.i_br_rs = $urandom;
      endcase
      bif.i_br_rt   = ($urandom_range(0, 1) != 0) ? bif.i_br_rs : 32'($urandom_range(0, 3));
      bif.i_br_pc4  = $urandom & 32'hFFFF_FFFC;
      r = $urandom;
      bif.i_br_imm  = {{16{r[15]}}, r[15:0]};
      bif.i_br_jidx = 26'($urandom);
      cyc();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
